// File: rtl/mc_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback strobes.
// Optional ILLEGAL_TRAP_EN: illegal opcodes and bus errors park the FSM in TRAP until reset.
module mc_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       br_taken,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_ifetch,
  output logic       ir_we,
  output logic       pc_we,
  output logic       pc_src,
  output logic       reg_we,
  output logic [1:0] wb_sel,
  output logic [1:0] src_a_sel,
  output logic [1:0] src_b_sel,
  output logic [2:0] alu_op,
  output logic       instr_done,
  output logic       bus_err,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_RST    = 3'b000,
    S_FETCH  = 3'b001,
    S_DECODE = 3'b010,
    S_EXEC   = 3'b011,
    S_MEM    = 3'b100,
    S_WB     = 3'b101,
    S_TRAP   = 3'b110
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

`ifdef ILLEGAL_TRAP_EN
  localparam state_t ABORT_ST = S_TRAP;
`else
  localparam state_t ABORT_ST = S_FETCH;
`endif

  state_t          st, st_nxt;
  logic [TO_W-1:0] cnt;
  logic            legal, req_state, to_fire;

  assign legal = (opcode == OP_R)      || (opcode == OP_I)     || (opcode == OP_LUI)  ||
                 (opcode == OP_AUIPC)  || (opcode == OP_LOAD)  || (opcode == OP_STORE) ||
                 (opcode == OP_BRANCH) || (opcode == OP_JAL)   || (opcode == OP_JALR);

  // Timeout is derived from state rather than mem_req to keep the decode loop-free.
  assign req_state = (st == S_FETCH) || (st == S_MEM);
  assign to_fire   = (TIMEOUT != 0) && req_state && !mem_ack && (cnt == TO_LAST);
  assign state     = st;

  always_comb begin
    st_nxt     = st;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_ifetch = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 1'b0;
    reg_we     = 1'b0;
    wb_sel     = 2'b00;
    src_a_sel  = 2'b00;
    src_b_sel  = 2'b00;
    alu_op     = 3'b000;
    instr_done = 1'b0;
    bus_err    = 1'b0;
    case (st)
      S_RST: st_nxt = S_FETCH;
      S_FETCH: begin
        mem_req    = 1'b1;
        mem_ifetch = 1'b1;
        src_b_sel  = 2'b10;
        if (mem_ack) begin
          ir_we  = 1'b1;
          pc_we  = 1'b1;
          st_nxt = S_DECODE;
        end else if (to_fire) begin
          bus_err = 1'b1;
          st_nxt  = ABORT_ST;
        end
      end
      S_DECODE: begin
        src_a_sel = 2'b01;
        src_b_sel = 2'b01;
        if (legal) begin
          st_nxt = S_EXEC;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          st_nxt = S_TRAP;
`else
          instr_done = 1'b1;
          st_nxt     = S_FETCH;
`endif
        end
      end
      S_EXEC: begin
        st_nxt = S_WB;
        case (opcode)
          OP_R:     begin alu_op = 3'b011; src_a_sel = 2'b10; end
          OP_I:     begin alu_op = 3'b101; src_a_sel = 2'b10; src_b_sel = 2'b01; end
          OP_LUI:   begin alu_op = 3'b010; src_b_sel = 2'b01; end
          OP_AUIPC: begin src_a_sel = 2'b01; src_b_sel = 2'b01; end
          OP_LOAD, OP_STORE: begin
            src_a_sel = 2'b10;
            src_b_sel = 2'b01;
            st_nxt    = S_MEM;
          end
          OP_BRANCH: begin
            alu_op     = 3'b001;
            src_a_sel  = 2'b10;
            pc_we      = br_taken;
            pc_src     = 1'b1;
            instr_done = 1'b1;
            st_nxt     = S_FETCH;
          end
          // Link value is the already-incremented PC; PC and rd write on the same edge.
          OP_JAL: begin
            pc_we      = 1'b1;
            pc_src     = 1'b1;
            reg_we     = 1'b1;
            wb_sel     = 2'b10;
            instr_done = 1'b1;
            st_nxt     = S_FETCH;
          end
          OP_JALR: begin
            alu_op     = 3'b100;
            src_a_sel  = 2'b10;
            src_b_sel  = 2'b01;
            pc_we      = 1'b1;
            reg_we     = 1'b1;
            wb_sel     = 2'b10;
            instr_done = 1'b1;
            st_nxt     = S_FETCH;
          end
          default: st_nxt = S_FETCH;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (opcode == OP_STORE);
        if (mem_ack) begin
          if (opcode == OP_STORE) begin
            instr_done = 1'b1;
            st_nxt     = S_FETCH;
          end else begin
            st_nxt = S_WB;
          end
        end else if (to_fire) begin
          bus_err = 1'b1;
          st_nxt  = ABORT_ST;
        end
      end
      S_WB: begin
        reg_we     = 1'b1;
        wb_sel     = (opcode == OP_LOAD) ? 2'b01 : 2'b00;
        instr_done = 1'b1;
        st_nxt     = S_FETCH;
      end
      S_TRAP:  st_nxt = S_TRAP;
      default: st_nxt = S_RST;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st  <= S_RST;
      cnt <= '0;
    end else begin
      st <= st_nxt;
      // Counter only runs while a request is outstanding; it saturates rather than wraps.
      if (!req_state || mem_ack || to_fire) begin
        cnt <= '0;
      end else if (cnt != '1) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
